// File: rtl/conv_sched_pkg.sv
// Shared state encoding and default frame sizing for the conv_16_4_16_1 scheduler.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int X_COUNT_DEF = 16;
    localparam int F_COUNT_DEF = 4;
    localparam int OP_COUNT    = X_COUNT_DEF - F_COUNT_DEF + 1;
    localparam int XCNT_W      = $clog2(X_COUNT_DEF + 1);
    localparam int OPCNT_W     = $clog2(OP_COUNT + 1);

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/conv_16_4_16_1_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping at N_REQ.
module rr_arbiter #(
    parameter int  N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_vld
);

    logic [IDX_W:0] cand;

    // Walk candidates from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        gnt_idx = '0;
        any_vld = 1'b0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt_idx = cand[IDX_W-1:0];
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_16_4_16_1_sched.sv
// Shares one conv_16_4_16_1 engine between N_REQ stream requesters, one whole frame per grant.
module conv_16_4_16_1_sched
    import conv_sched_pkg::*;
#(
    parameter int  T       = 16,
    parameter int  N_REQ   = 2,
    parameter int  X_COUNT = X_COUNT_DEF,
    parameter int  F_COUNT = F_COUNT_DEF,
    localparam int G_W     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ*T-1:0] s_data_in_x,
    input  logic [N_REQ-1:0]   s_valid_x,
    output logic [N_REQ-1:0]   s_ready_x,
    output logic [N_REQ*T-1:0] m_data_out_y,
    output logic [N_REQ-1:0]   m_valid_y,
    input  logic [N_REQ-1:0]   m_ready_y,
    output logic [T-1:0]       e_data_in_x,
    output logic               e_valid_x,
    input  logic               e_ready_x,
    input  logic [T-1:0]       e_data_out_y,
    input  logic               e_valid_y,
    output logic               e_ready_y,
    output logic [G_W-1:0]     grant,
    output logic               busy
);

    localparam int OP_N = X_COUNT - F_COUNT + 1;
    localparam int XW   = cnt_w(X_COUNT);
    localparam int YW   = cnt_w(OP_N);

    state_t         state_q, state_d;
    logic [G_W-1:0] grant_q, grant_d;
    logic [G_W-1:0] rr_q, rr_d;
    logic [XW-1:0]  xcnt_q, xcnt_d;
    logic [YW-1:0]  ycnt_q, ycnt_d;
    logic [G_W-1:0] arb_idx;
    logic           arb_any;
    logic           x_hs;
    logic           y_hs;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req    (s_valid_x),
        .ptr    (rr_q),
        .gnt_idx(arb_idx),
        .any_vld(arb_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            xcnt_q  <= '0;
            ycnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            xcnt_q  <= xcnt_d;
            ycnt_q  <= ycnt_d;
        end
    end

    // All steering is combinational off the registered grant, so a granted port sees zero added latency.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        xcnt_d       = xcnt_q;
        ycnt_d       = ycnt_q;
        s_ready_x    = '0;
        m_valid_y    = '0;
        m_data_out_y = '0;
        e_data_in_x  = '0;
        e_valid_x    = 1'b0;
        e_ready_y    = 1'b0;
        busy         = 1'b0;
        x_hs         = 1'b0;
        y_hs         = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    xcnt_d  = '0;
                    ycnt_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy               = 1'b1;
                e_data_in_x        = s_data_in_x[grant_q*T +: T];
                e_valid_x          = s_valid_x[grant_q];
                s_ready_x[grant_q] = e_ready_x;
                x_hs               = s_valid_x[grant_q] & e_ready_x;
                if (x_hs) begin
                    xcnt_d = xcnt_q + XW'(1);
                    if (xcnt_q == XW'(X_COUNT - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy                          = 1'b1;
                m_data_out_y[grant_q*T +: T]  = e_data_out_y;
                m_valid_y[grant_q]            = e_valid_y;
                e_ready_y                     = m_ready_y[grant_q];
                y_hs                          = e_valid_y & m_ready_y[grant_q];
                if (y_hs) begin
                    ycnt_d = ycnt_q + YW'(1);
                    if (ycnt_q == YW'(OP_N - 1)) begin
                        state_d = IDLE;
                        rr_d    = (grant_q == G_W'(N_REQ - 1)) ? '0 : grant_q + G_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_conv_16_4_16_1_sched.sv
// Directed bench for conv_16_4_16_1_sched with a behavioural engine and per-port result scoreboard.
module tb_conv_16_4_16_1_sched;

    localparam int T   = 16;
    localparam int N   = 4;
    localparam int GW  = 2;
    localparam int XC  = 16;
    localparam int FC  = 4;
    localparam int OPC = XC - FC + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*T-1:0] s_data_in_x;
    logic [N-1:0]   s_valid_x;
    logic [N-1:0]   s_ready_x;
    logic [N*T-1:0] m_data_out_y;
    logic [N-1:0]   m_valid_y;
    logic [N-1:0]   m_ready_y;
    logic [T-1:0]   e_data_in_x;
    logic           e_valid_x;
    logic           e_ready_x;
    logic [T-1:0]   e_data_out_y;
    logic           e_valid_y;
    logic           e_ready_y;
    logic [GW-1:0]  grant;
    logic           busy;

    always #5 clk = ~clk;

    conv_16_4_16_1_sched #(
        .T(T), .N_REQ(N), .X_COUNT(XC), .F_COUNT(FC)
    ) dut (
        .clk(clk), .reset(reset),
        .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
        .e_data_in_x(e_data_in_x), .e_valid_x(e_valid_x), .e_ready_x(e_ready_x),
        .e_data_out_y(e_data_out_y), .e_valid_y(e_valid_y), .e_ready_y(e_ready_y),
        .grant(grant), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [T-1:0] src_q[N][$];
    logic [T-1:0] exp_q[N][$];
    logic [T-1:0] res_log[N][$];
    int           grant_log[$];
    int           gap_log[$];
    int           acc_cnt[N];
    int           first_cyc[N];
    int           last_cyc[N];
    bit           act_seen[N];
    bit           tog_en[N];
    bit           eng_stall;
    bit           busy_prev = 1'b0;
    int           idle_run  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int tap(input int k);
        case (k)
            0:       return 252;
            1:       return 70;
            2:       return -33;
            default: return 17;
        endcase
    endfunction

    // Valid-window correlation: y[n] = sum_k x[n+k]*h[k], wrapped to T bits.
    function automatic logic [T-1:0] conv_at(input int fr[XC], input int n);
        int acc;
        acc = 0;
        for (int k = 0; k < FC; k++) acc += fr[n+k] * tap(k);
        return acc[T-1:0];
    endfunction

    // Engine stand-in: takes XC samples, then offers OPC results and holds each until taken.
    int eng_buf[XC];
    int eng_in_cnt  = 0;
    int eng_out_cnt = 0;
    bit eng_draining = 1'b0;
    initial begin
        bit           rs, ihs, ohs;
        logic [T-1:0] din;
        e_ready_x    = 1'b1;
        e_valid_y    = 1'b0;
        e_data_out_y = 16'hdead;
        forever begin
            @(negedge clk);
            rs  = reset;
            ihs = e_valid_x & e_ready_x;
            ohs = e_valid_y & e_ready_y;
            din = e_data_in_x;
            @(posedge clk);
            #1;
            if (rs) begin
                eng_in_cnt   = 0;
                eng_out_cnt  = 0;
                eng_draining = 1'b0;
            end else begin
                if (ihs) begin
                    eng_buf[eng_in_cnt] = int'($signed(din));
                    eng_in_cnt++;
                    if (eng_in_cnt == XC) begin
                        eng_draining = 1'b1;
                        eng_out_cnt  = 0;
                    end
                end
                if (ohs) begin
                    eng_out_cnt++;
                    if (eng_out_cnt == OPC) begin
                        eng_draining = 1'b0;
                        eng_in_cnt   = 0;
                    end
                end
            end
            e_ready_x    = !eng_draining && !eng_stall;
            e_valid_y    = eng_draining;
            e_data_out_y = eng_draining ? conv_at(eng_buf, eng_out_cnt) : 16'hdead;
        end
    end

    // Stream sources: present the head of each port's queue, optionally gated every other cycle.
    initial begin
        bit           rs;
        bit           phase;
        logic [N-1:0] hs;
        s_valid_x   = '0;
        s_data_in_x = '0;
        phase       = 1'b0;
        forever begin
            @(negedge clk);
            rs = reset;
            hs = s_valid_x & s_ready_x;
            @(posedge clk);
            #1;
            phase = ~phase;
            for (int i = 0; i < N; i++) begin
                if (!rs && hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                s_valid_x[i] = (src_q[i].size() > 0) && (!tog_en[i] || phase);
                s_data_in_x[i*T +: T] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
        end
    end

    // Compare process: steering, quiet-port rules and every delivered result.
    always @(negedge clk) begin
        logic [T-1:0] expv;
        cyc++;
        if (busy && !busy_prev) begin
            grant_log.push_back(int'(grant));
            gap_log.push_back(idle_run);
        end
        idle_run  = busy ? 0 : idle_run + 1;
        busy_prev = busy;
        if (!reset) begin
            if (!busy) begin
                check("idle_quiet", 32'(|{s_ready_x, m_valid_y, e_valid_x, e_ready_y, m_data_out_y, e_data_in_x}), 0);
            end
            if (s_ready_x != '0) begin
                check("ready_onehot", 32'($countones(s_ready_x)), 1);
                check("load_no_result", 32'({m_valid_y, e_ready_y}), 0);
            end
            if (m_valid_y != '0) begin
                check("valid_onehot", 32'($countones(m_valid_y)), 1);
                check("drain_no_sample", 32'({s_ready_x, e_valid_x}), 0);
            end
            for (int i = 0; i < N; i++) begin
                if (s_ready_x[i] || m_valid_y[i]) act_seen[i] = 1'b1;
                if (s_ready_x[i]) begin
                    check($sformatf("x_data_p%0d", i), 32'(e_data_in_x), 32'(s_data_in_x[i*T +: T]));
                    check($sformatf("x_valid_p%0d", i), 32'(e_valid_x), 32'(s_valid_x[i]));
                    if (s_valid_x[i]) begin
                        acc_cnt[i]++;
                        if (first_cyc[i] < 0) first_cyc[i] = cyc;
                        last_cyc[i] = cyc;
                    end
                end
                if (m_valid_y[i]) begin
                    check($sformatf("y_data_p%0d", i), 32'(m_data_out_y[i*T +: T]), 32'(e_data_out_y));
                    check($sformatf("y_ready_p%0d", i), 32'(e_ready_y), 32'(m_ready_y[i]));
                    if (m_ready_y[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check($sformatf("unexpected_result_p%0d", i), 1, 0);
                        end else begin
                            expv = exp_q[i].pop_front();
                            check($sformatf("result_p%0d", i), 32'(m_data_out_y[i*T +: T]), 32'(expv));
                        end
                        res_log[i].push_back(m_data_out_y[i*T +: T]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input int p, input int fr[XC]);
        for (int j = 0; j < XC; j++) src_q[p].push_back(T'(fr[j]));
        for (int n = 0; n < OPC; n++) exp_q[p].push_back(conv_at(fr, n));
    endtask

    task automatic rand_frame(output int fr[XC]);
        for (int j = 0; j < XC; j++) fr[j] = int'($signed(16'($urandom_range(0, 65535))));
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_done(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            done = all_empty() && !busy;
        end
        check(name, 32'(done), 1);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < N; i++) begin
            res_log[i].delete();
            act_seen[i]  = 1'b0;
            acc_cnt[i]   = 0;
            first_cyc[i] = -1;
            last_cyc[i]  = -1;
        end
        grant_log.delete();
        gap_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready_x), 0);
        check({tag, "_m_valid"}, 32'(m_valid_y), 0);
        check({tag, "_m_data"}, 32'(|m_data_out_y), 0);
        check({tag, "_e_valid_x"}, 32'(e_valid_x), 0);
        check({tag, "_e_ready_y"}, 32'(e_ready_y), 0);
        check({tag, "_e_data_in"}, 32'(e_data_in_x), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int fr[XC];
        int eg[4];
        bit reached;
        reset     = 1'b1;
        m_ready_y = '1;
        eng_stall = 1'b0;
        for (int i = 0; i < N; i++) tog_en[i] = 1'b0;
        clear_logs();
        tick();
        tick();
        check_reset_outputs("por");
        reset = 1'b0;

        // Pin the reference arithmetic with hand-computed values.
        for (int j = 0; j < XC; j++) fr[j] = 0;
        fr[0] = 1;
        fr[1] = 1;
        check("model_y0", 32'(conv_at(fr, 0)), 322);
        check("model_y1", 32'(conv_at(fr, 1)), 252);
        check("model_y2", 32'(conv_at(fr, 2)), 0);
        for (int j = 0; j < XC; j++) fr[j] = j + 1;
        check("model_ramp_y0", 32'(conv_at(fr, 0)), 361);

        // Single frame on port 0 with a two-sample impulse.
        clear_logs();
        for (int j = 0; j < XC; j++) fr[j] = 0;
        fr[0] = 1;
        fr[1] = 1;
        send_frame(0, fr);
        wait_done("t1_done", 300);
        check("t1_count", 32'(res_log[0].size()), OPC);
        if (res_log[0].size() == OPC) begin
            check("t1_y0", 32'(res_log[0][0]), 322);
            check("t1_y1", 32'(res_log[0][1]), 252);
            check("t1_y2", 32'(res_log[0][2]), 0);
            check("t1_y12", 32'(res_log[0][12]), 0);
        end
        check("t1_port1_silent", 32'(act_seen[1]), 0);

        // Two requesters contending from reset: strict alternation, one idle cycle between frames.
        do_reset();
        clear_logs();
        for (int f = 0; f < 2; f++) begin
            rand_frame(fr);
            send_frame(0, fr);
            rand_frame(fr);
            send_frame(1, fr);
        end
        wait_done("t2_done", 800);
        eg = '{0, 1, 0, 1};
        check("t2_frames", 32'(grant_log.size()), 4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("t2_grant%0d", k), 32'(grant_log[k]), 32'(eg[k]));
            for (int k = 1; k < 4; k++) check($sformatf("t2_gap%0d", k), 32'(gap_log[k]), 1);
        end

        // Port 1 alone with valid toggling every other cycle.
        clear_logs();
        tog_en[1] = 1'b1;
        rand_frame(fr);
        send_frame(1, fr);
        wait_done("t3_done", 400);
        tog_en[1] = 1'b0;
        check("t3_accepted", 32'(acc_cnt[1]), XC);
        check("t3_span", 32'(last_cyc[1] - first_cyc[1] + 1), 31);
        check("t3_results", 32'(res_log[1].size()), OPC);
        check("t3_port0_silent", 32'(act_seen[0]), 0);

        // Sink back-pressure mid-drain.
        clear_logs();
        rand_frame(fr);
        send_frame(0, fr);
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            tick();
            reached = (res_log[0].size() >= 4);
        end
        check("t4_reach_drain", 32'(reached), 1);
        m_ready_y[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_e_ready_low", 32'(e_ready_y), 0);
            check("t4_held_valid", 32'(m_valid_y[0]), 1);
        end
        m_ready_y[0] = 1'b1;
        wait_done("t4_done", 300);
        check("t4_results", 32'(res_log[0].size()), OPC);

        // Reset part-way through a load, then a clean frame with an engine stall.
        clear_logs();
        rand_frame(fr);
        send_frame(0, fr);
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            tick();
            reached = (acc_cnt[0] >= 8);
        end
        check("t5_reach_8", 32'(reached), 1);
        reset = 1'b1;
        src_q[0].delete();
        exp_q[0].delete();
        tick();
        check_reset_outputs("t5_rst");
        reset = 1'b0;
        clear_logs();
        rand_frame(fr);
        send_frame(0, fr);
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            tick();
            reached = (acc_cnt[0] >= 5);
        end
        check("t5_reach_5", 32'(reached), 1);
        eng_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_stall_no_ready", 32'(s_ready_x), 0);
            check("t5_stall_busy", 32'(busy), 1);
        end
        eng_stall = 1'b0;
        wait_done("t5_done", 300);
        check("t5_accepted", 32'(acc_cnt[0]), XC);
        check("t5_results", 32'(res_log[0].size()), OPC);

        // Pointer left at 2 by a port-1 frame; ports 1 and 3 then contend.
        clear_logs();
        rand_frame(fr);
        send_frame(1, fr);
        wait_done("t6_prep_done", 300);
        clear_logs();
        rand_frame(fr);
        send_frame(1, fr);
        rand_frame(fr);
        send_frame(3, fr);
        wait_done("t6_done", 600);
        check("t6_frames", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check("t6_first", 32'(grant_log[0]), 3);
            check("t6_second", 32'(grant_log[1]), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_16_4_16_1_sched.md
# conv_16_4_16_1_sched

Round-robin scheduler that shares one conv_16_4_16_1 engine (16-sample frame, 4-tap ROM filter, 16-bit) between N_REQ independent stream requesters. It grants the engine to one requester for a whole frame, steers that requester's X_COUNT input samples into the engine, and routes the engine's OP_COUNT results back to the same requester's output port. It sits between the stream sources/sinks and the single engine instance.

## Interface
- T, 16, sample/result width (signed)
- N_REQ, 2, number of requesters (2..8)
- X_COUNT, 16, input samples per frame
- F_COUNT, 4, filter taps
- OP_COUNT, X_COUNT-F_COUNT+1 (13), results per frame
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_data_in_x  in  N_REQ×T  per-requester input sample
- s_valid_x  in  N_REQ  per-requester input valid
- s_ready_x  out  N_REQ  per-requester input ready
- m_data_out_y  out  N_REQ×T  per-requester result
- m_valid_y  out  N_REQ  per-requester result valid
- m_ready_y  in  N_REQ  per-requester result ready
- e_data_in_x  out  T  to engine s_data_in_x
- e_valid_x  out  1  to engine s_valid_x
- e_ready_x  in  1  from engine s_ready_x
- e_data_out_y  in  T  from engine m_data_out_y
- e_valid_y  in  1  from engine m_valid_y
- e_ready_y  out  1  to engine m_ready_y
- grant  out  $clog2(N_REQ)  current/last granted requester
- busy  out  1  high in LOAD or DRAIN

## Operation
- States: IDLE, LOAD, DRAIN. Reset → IDLE, rr pointer = 0, grant = 0, counters = 0.
- IDLE: if any s_valid_x set, pick first set bit searching from rr pointer upward (wrap at N_REQ); register grant, go LOAD. Otherwise stay. No samples are accepted in IDLE (all s_ready_x = 0).
- LOAD: e_data_in_x = s_data_in_x[grant]; e_valid_x = s_valid_x[grant]; s_ready_x[grant] = e_ready_x; all other s_ready_x = 0. Count handshakes (e_valid_x & e_ready_x); on the X_COUNT-th, go DRAIN.
- DRAIN: m_data_out_y[grant] = e_data_out_y, m_valid_y[grant] = e_valid_y, e_ready_y = m_ready_y[grant]. Count handshakes (e_valid_y & e_ready_y); on the OP_COUNT-th, go IDLE, rr pointer = grant+1 mod N_REQ.
- Non-granted ports, and all ports outside their active state: s_ready_x = 0, m_valid_y = 0, m_data_out_y = 0. e_valid_x = 0 outside LOAD, e_ready_y = 0 outside DRAIN, e_data_in_x = 0 outside LOAD.
- Sample counter width $clog2(X_COUNT+1); result counter width $clog2(OP_COUNT+1); both cleared on entering LOAD.
- Data is passed through unmodified; no arithmetic in this block.

## Timing
- Reset values: s_ready_x = 0, m_valid_y = 0, m_data_out_y = 0, e_valid_x = 0, e_ready_y = 0, e_data_in_x = 0, grant = 0, busy = 0.
- Arbitration latency: 1 cycle (request visible in IDLE → first possible sample handshake next cycle).
- Data/valid/ready steering is combinational from registered state/grant: zero added latency.
- Requester dropping s_valid_x mid-frame: bubble, counter holds; grant is never revoked mid-frame.
- Engine dropping e_ready_x during LOAD: no handshake counted.
- Requester dropping m_ready_y in DRAIN: e_ready_y low, engine holds result.
- Last result handshake with requests pending: IDLE for exactly 1 cycle, then next grant.
- Requester asserting s_valid_x while not granted: ignored, waits; no data loss.
- Reset mid-frame: immediate return to IDLE; engine shares the same reset.

## Structure
- Package conv_sched_pkg: state enum (IDLE, LOAD, DRAIN), localparams OP_COUNT and counter widths.
- One sub-module: rr_arbiter (N_REQ request vector + pointer in, grant index + any-valid out, combinational).

## Test plan
- Single frame, req 0: x = [1,1,0×14] → m_valid_y[0] pulses 13 times, results [322,252,0×11]; port 1 silent, s_ready_x[1] = 0 throughout.
- Both requesters valid from reset → grant order 0,1,0,1 over 4 frames; busy low exactly 1 cycle between frames.
- Req 1 alone with valid toggling every other cycle → 16 samples accepted over 31 cycles, results correct on port 1.
- m_ready_y[0] held low 5 cycles mid-DRAIN → e_ready_y low, no results lost, count still 13.
- Reset asserted after 8 samples of a frame → next cycle IDLE, all outputs at reset values; new frame computes correctly.
- N_REQ = 4, requests on 1 and 3 only, pointer at 2 → grant 3 first, then 1.
